// File: rtl/jt7759_rom_srv_if.sv
// Byte ROM port and 16-bit memory port bundle for jt7759_rom_srv.
// slave is the server's view; master is the requester/memory side.
interface jt7759_rom_srv_if #(
  parameter int AW = 17
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          flush;
  logic          mem_req;
  logic [AW-2:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_dout;
  logic          err;

  modport slave (
    input  rom_cs, rom_addr, flush,
    input  mem_ack, mem_dout,
    output rom_data, rom_ok,
    output mem_req, mem_addr, err
  );

  modport master (
    output rom_cs, rom_addr, flush,
    output mem_ack, mem_dout,
    input  rom_data, rom_ok,
    input  mem_req, mem_addr, err
  );
endinterface

// File: rtl/jt7759_rom_srv.sv
// Byte ROM server over a 16-bit req/ack memory port.
// One-word cache, fetch timeout with retry, sticky err.
module jt7759_rom_srv #(
  parameter int AW   = 17,
  parameter int TOW  = 8,
  parameter int TOUT = 200
) (
  input  logic clk,
  input  logic rstn,
  jt7759_rom_srv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RETRY
  } st_t;

  st_t           state, state_nx;
  logic          valid;
  logic          stale;
  logic [AW-2:0] tag;
  logic [15:0]   word;
  logic [TOW-1:0] cnt;

  logic hit;
  logic issue;
  logic take;
  logic tmo;

  assign hit = valid && (tag == bus.rom_addr[AW-1:1]);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    take     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rom_cs && !hit && !bus.flush) begin
          issue    = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          take     = 1'b1;
          state_nx = IDLE;
        end else if (cnt == TOW'(TOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = RETRY;
        end
      end
      RETRY: begin
        state_nx = FETCH;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      valid        <= 1'b0;
      stale        <= 1'b0;
      tag          <= '0;
      word         <= '0;
      cnt          <= '0;
      bus.rom_ok   <= 1'b0;
      bus.rom_data <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.err      <= 1'b0;
    end else begin
      state      <= state_nx;
      bus.rom_ok <= bus.rom_cs && hit && !bus.flush;
      if (hit) begin
        bus.rom_data <= bus.rom_addr[0] ? word[15:8]
                                        : word[7:0];
      end
      if (state == FETCH) begin
        cnt <= cnt + 1'b1;
      end
      if (issue) begin
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= bus.rom_addr[AW-1:1];
        cnt          <= '0;
        stale        <= 1'b0;
      end
      if (take) begin
        bus.mem_req <= 1'b0;
        if (!stale && !bus.flush) begin
          word  <= bus.mem_dout;
          tag   <= bus.mem_addr;
          valid <= 1'b1;
        end
      end
      if (tmo) begin
        bus.mem_req <= 1'b0;
        bus.err     <= 1'b1;
      end
      if (state == RETRY) begin
        bus.mem_req <= 1'b1;
        cnt         <= '0;
      end
      // flush drops the cache and poisons any fetch still in flight
      if (bus.flush) begin
        valid <= 1'b0;
        if (state != IDLE) begin
          stale <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt7759_rom_srv.sv
// Directed bench for jt7759_rom_srv with TOUT=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_jt7759_rom_srv;

  localparam int AW = 17;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  jt7759_rom_srv_if #(.AW(AW)) bus ();

  jt7759_rom_srv #(
    .AW  (AW),
    .TOW (8),
    .TOUT(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    bus.rom_cs   = 1'b0;
    bus.rom_addr = '0;
    bus.flush    = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    repeat (3) nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rom_ok got=%b exp=0", bus.rom_ok);
    end
    n_chk++;
    if (bus.rom_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_rom_data got=%h exp=00", bus.rom_data);
    end
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mem got=%b/%h exp=0/0000",
               bus.mem_req, bus.mem_addr);
    end
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err got=%b exp=0", bus.err);
    end
    rstn = 1'b1;
  endtask

  task automatic test_cold_read();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 17'h00005;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0002) begin
      n_fail++;
      $display("FAIL cold_req got=%b/%h exp=1/0002",
               bus.mem_req, bus.mem_addr);
    end
    nxt();
    nxt();
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'hA55A;
    nxt();
    bus.mem_ack = 1'b0;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_ack got=req%b ok%b exp=req0 ok0",
               bus.mem_req, bus.rom_ok);
    end
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL cold_data got=%b/%h exp=1/a5",
               bus.rom_ok, bus.rom_data);
    end
  endtask

  task automatic test_same_word_hit();
    bus.rom_addr = 17'h00004;
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL hit_data got=%b/%h exp=1/5a",
               bus.rom_ok, bus.rom_data);
    end
    n_chk++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_noreq got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_addr_change();
    bus.rom_addr = 17'h00010;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0008) begin
      n_fail++;
      $display("FAIL chg_req1 got=%b/%h exp=1/0008",
               bus.mem_req, bus.mem_addr);
    end
    bus.rom_addr = 17'h00020;
    nxt();
    n_chk++;
    if (bus.mem_addr !== 16'h0008) begin
      n_fail++;
      $display("FAIL chg_hold got=%h exp=0008", bus.mem_addr);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'h1234;
    nxt();
    bus.mem_ack = 1'b0;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_gap got=req%b ok%b exp=req0 ok0",
               bus.mem_req, bus.rom_ok);
    end
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL chg_req2 got=%b/%h exp=1/0010",
               bus.mem_req, bus.mem_addr);
    end
    n_chk++;
    if (bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_early_ok got=%b exp=0", bus.rom_ok);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'hBEEF;
    nxt();
    bus.mem_ack = 1'b0;
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'hEF) begin
      n_fail++;
      $display("FAIL chg_data got=%b/%h exp=1/ef",
               bus.rom_ok, bus.rom_data);
    end
  endtask

  task automatic test_timeout();
    bus.rom_addr = 17'h00040;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL to_req got=%b/%h exp=1/0020",
               bus.mem_req, bus.mem_addr);
    end
    repeat (3) nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_4th got=req%b err%b exp=req1 err0",
               bus.mem_req, bus.err);
    end
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_drop got=req%b err%b exp=req0 err1",
               bus.mem_req, bus.err);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'hDEAD;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL to_retry got=%b/%h exp=1/0020",
               bus.mem_req, bus.mem_addr);
    end
    bus.mem_dout = 16'h7788;
    nxt();
    bus.mem_ack = 1'b0;
    n_chk++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_ack got=%b exp=0", bus.mem_req);
    end
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h88) begin
      n_fail++;
      $display("FAIL to_data got=%b/%h exp=1/88",
               bus.rom_ok, bus.rom_data);
    end
    n_chk++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky got=%b exp=1", bus.err);
    end
  endtask

  task automatic test_flush_ack();
    bus.rom_addr = 17'h00080;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL fl_req got=%b/%h exp=1/0040",
               bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack  = 1'b1;
    bus.flush    = 1'b1;
    bus.mem_dout = 16'h1111;
    nxt();
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;
    n_chk++;
    if (bus.rom_ok !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_ack got=ok%b req%b exp=ok0 req0",
               bus.rom_ok, bus.mem_req);
    end
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040 ||
        bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_refetch got=%b/%h ok%b exp=1/0040 ok0",
               bus.mem_req, bus.mem_addr, bus.rom_ok);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'h2233;
    nxt();
    bus.mem_ack = 1'b0;
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'h33) begin
      n_fail++;
      $display("FAIL fl_data got=%b/%h exp=1/33",
               bus.rom_ok, bus.rom_data);
    end
  endtask

  task automatic test_async_reset();
    bus.rom_addr = 17'h00100;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0080) begin
      n_fail++;
      $display("FAIL ar_req got=%b/%h exp=1/0080",
               bus.mem_req, bus.mem_addr);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.rom_ok !== 1'b0 ||
        bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_async got=req%b ok%b err%b exp=0 0 0",
               bus.mem_req, bus.rom_ok, bus.err);
    end
    nxt();
    rstn         = 1'b1;
    bus.rom_addr = 17'h00003;
    nxt();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL ar_req2 got=%b/%h exp=1/0001",
               bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_dout = 16'hC0DE;
    nxt();
    bus.mem_ack = 1'b0;
    n_chk++;
    if (bus.rom_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_early_ok got=%b exp=0", bus.rom_ok);
    end
    nxt();
    n_chk++;
    if (bus.rom_ok !== 1'b1 || bus.rom_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL ar_data got=%b/%h exp=1/c0",
               bus.rom_ok, bus.rom_data);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_cold_read();
    test_same_word_hit();
    test_addr_change();
    test_timeout();
    test_flush_ack();
    test_async_reset();
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
